// File: rtl/bram_stream_reader_pkg.sv
// Shared constants, FSM state type and FIFO pointer helper for the BRAM stream reader.
package bram_stream_reader_pkg;

   localparam int DATA_W_DEF = 128;  // RAM port / stream word width
   localparam int ADDR_W_DEF = 8;    // RAM address width (256 words)
   localparam int FIFO_DEPTH = 3;    // skid FIFO entries, fixed

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Advance a skid FIFO pointer, wrapping after the last entry.
   function automatic logic [1:0] fifo_ptr_inc(input logic [1:0] ptr);
      return (ptr == 2'(FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
   endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Command, RAM-port and output-stream signals of the BRAM stream reader.
// The master modport is the reader itself; slave is the surrounding logic.
interface bram_stream_reader_if #(
   parameter int DATA_W = bram_stream_reader_pkg::DATA_W_DEF,
   parameter int ADDR_W = bram_stream_reader_pkg::ADDR_W_DEF
);
   // burst command
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] cmd_len;
   // RAM read port
   logic              bram_en;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_dout;
   // output stream
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   // status
   logic              busy;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len, bram_dout, out_ready,
      output cmd_ready, bram_en, bram_we, bram_addr,
             out_valid, out_data, out_last, busy
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len, bram_dout, out_ready,
      input  cmd_ready, bram_en, bram_we, bram_addr,
             out_valid, out_data, out_last, busy
   );
endinterface

// File: rtl/bram_stream_reader_skid_fifo.sv
// 3-entry circular skid FIFO holding {last, data}; the head is read combinationally.
// Push while full is only accepted together with a pop.
module bram_skid_fifo #(
   parameter int WIDTH = bram_stream_reader_pkg::DATA_W_DEF + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [1:0]       o_count,
   output logic             o_empty
);
   import bram_stream_reader_pkg::*;

   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [1:0]       r_wr_ptr;
   logic [1:0]       r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign w_pop_ok  = i_pop && (r_count != 2'd0);
   assign w_push_ok = i_push && ((r_count != 2'(FIFO_DEPTH)) || w_pop_ok);

   // Storage: write the tail entry on push.
   // NOTE: the storage is reset because the head drives out_data directly and
   // must read as zero after reset; with only three entries this is cheap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push_ok) begin
         // NOTE: sequential state always uses non-blocking assignments so every
         // flop samples pre-edge values regardless of block ordering.
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 2'd0;
         r_rd_ptr <= 2'd0;
         r_count  <= 2'd0;
      end else begin
         if (w_push_ok) r_wr_ptr <= fifo_ptr_inc(r_wr_ptr);
         if (w_pop_ok)  r_rd_ptr <= fifo_ptr_inc(r_rd_ptr);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/bram_stream_reader.sv
// Burst reader: takes (addr, len) commands, issues sequential single-word reads to
// a BRAM port with 1-cycle read latency and streams the words out with a last flag.
// Reads are credit-limited so the 3-entry skid FIFO can never overflow.
module bram_stream_reader #(
   parameter int DATA_W = bram_stream_reader_pkg::DATA_W_DEF,
   parameter int ADDR_W = bram_stream_reader_pkg::ADDR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bram_stream_reader_if.master bus
);
   import bram_stream_reader_pkg::*;

   state_t            r_state;
   state_t            w_state_next;
   logic              r_bram_en;      // read asserted on the RAM port this cycle
   logic              r_rd_pending;   // read from last cycle, data on bram_dout now
   logic [ADDR_W-1:0] r_bram_addr;
   logic [ADDR_W-1:0] r_next_addr;    // address of the next read to schedule
   logic [ADDR_W-1:0] r_len;
   logic [ADDR_W-1:0] r_cap_cnt;      // words captured so far in this burst
   logic [ADDR_W:0]   r_rem;          // reads not yet scheduled

   logic              w_cmd_fire;
   logic              w_pop;
   logic              w_sched;
   logic              w_credit_ok;
   logic [2:0]        w_count_next;
   logic [ADDR_W-1:0] w_issue_addr;
   logic              w_last_cap;
   logic [DATA_W:0]   w_head;
   logic [1:0]        w_fifo_count;
   logic              w_fifo_empty;

   assign w_cmd_fire = bus.cmd_valid && (r_state == IDLE);
   assign w_pop      = !w_fifo_empty && bus.out_ready;

   // The read flop is loaded one cycle ahead, so the credit test uses the FIFO
   // occupancy and pending read that will be seen in the cycle the read happens.
   assign w_count_next = {1'b0, w_fifo_count} + {2'b00, r_rd_pending} - {2'b00, w_pop};
   assign w_credit_ok  = (w_count_next + {2'b00, r_bram_en}) < 3'(FIFO_DEPTH);
   assign w_sched      = w_credit_ok &&
                         (w_cmd_fire || ((r_state == ISSUE) && (r_rem != '0)));
   assign w_issue_addr = w_cmd_fire ? bus.cmd_addr : r_next_addr;
   assign w_last_cap   = (r_cap_cnt == r_len);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // FSM next-state: leave DRAIN on the pop of the word flagged last.
   // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_cmd_fire) w_state_next = ISSUE;
         ISSUE:   if (r_rem == '0) w_state_next = DRAIN;
         DRAIN:   if (w_pop && w_head[DATA_W]) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Read issue, address and burst counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bram_en    <= 1'b0;
         r_rd_pending <= 1'b0;
         r_bram_addr  <= '0;
         r_next_addr  <= '0;
         r_len        <= '0;
         r_cap_cnt    <= '0;
         r_rem        <= '0;
      end else begin
         r_bram_en    <= w_sched;
         r_rd_pending <= r_bram_en;
         if (w_sched) begin
            r_bram_addr <= w_issue_addr;
            r_next_addr <= w_issue_addr + ADDR_W'(1);
         end
         if (w_cmd_fire) begin
            r_len     <= bus.cmd_len;
            r_cap_cnt <= '0;
            r_rem     <= {1'b0, bus.cmd_len} + (w_sched ? '0 : (ADDR_W+1)'(1));
         end else begin
            if (w_sched)      r_rem     <= r_rem - (ADDR_W+1)'(1);
            if (r_rd_pending) r_cap_cnt <= r_cap_cnt + ADDR_W'(1);
         end
      end
   end

   bram_skid_fifo #(.WIDTH(DATA_W + 1)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_rd_pending),
      .i_din   ({w_last_cap, bus.bram_dout}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty)
   );

   assign bus.cmd_ready = (r_state == IDLE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.bram_en   = r_bram_en;
   assign bus.bram_we   = 1'b0;
   assign bus.bram_addr = r_bram_addr;
   assign bus.out_valid = !w_fifo_empty;
   assign bus.out_data  = w_head[DATA_W-1:0];
   assign bus.out_last  = w_head[DATA_W];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: a RAM model with 1-cycle read latency,
// a port monitor that rebuilds FIFO occupancy from bram_en/pop traffic, and
// per-burst checks of addresses, data, last flags and handshake timing.
module tb_bram_stream_reader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   bram_stream_reader_if bus ();

   bram_stream_reader u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Deterministic, address-unique RAM contents.
   function automatic logic [127:0] word_of(input logic [7:0] a);
      return {a, 24'hC0FFEE, ~a, 24'h5A5A5A, 8'(a + 8'd3), 24'h123456, 8'(a ^ 8'h96), 24'hFACADE};
   endfunction

   logic [127:0] ram [256];
   always @(posedge clk) begin
      if (bus.bram_en) bus.bram_dout <= ram[bus.bram_addr];
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor state
   logic [7:0]   q_addr [$];
   int           q_en_cyc [$];
   logic [127:0] q_data [$];
   bit           q_last [$];
   int           q_pop_cyc [$];
   int           m_count = 0;
   int           prev_en = 0;
   bit           prev_rdy = 1'b1;
   int           viol = 0;
   int           full_seen = 0;
   int           n_fire = 0;
   int           fire_cyc = 0;
   int           rdy_rise = 0;

   always @(negedge clk) begin
      bit pop;
      if (!rst_n) begin
         m_count  = 0;
         prev_en  = 0;
         prev_rdy = 1'b1;
      end else begin
         pop = bus.out_valid && bus.out_ready;
         if (m_count > 3) viol++;
         if (bus.out_valid != (m_count != 0)) viol++;
         if (m_count + prev_en == 3) begin
            full_seen++;
            if (bus.bram_en) viol++;
         end
         if (bus.bram_en) begin
            q_addr.push_back(bus.bram_addr);
            q_en_cyc.push_back(cyc);
         end
         if (pop) begin
            q_data.push_back(bus.out_data);
            q_last.push_back(bus.out_last);
            q_pop_cyc.push_back(cyc);
         end
         if (bus.cmd_valid && bus.cmd_ready) begin
            n_fire++;
            fire_cyc = cyc;
         end
         if (bus.cmd_ready && !prev_rdy) rdy_rise = cyc;
         prev_rdy = bus.cmd_ready;
         m_count  = m_count + prev_en - (pop ? 1 : 0);
         prev_en  = bus.bram_en ? 1 : 0;
      end
   end

   task automatic clear_q();
      q_addr.delete();
      q_en_cyc.delete();
      q_data.delete();
      q_last.delete();
      q_pop_cyc.delete();
      viol      = 0;
      full_seen = 0;
      n_fire    = 0;
   endtask

   // Called and returns at 1 time unit after a rising edge.
   task automatic send_cmd(input string tag, input logic [7:0] a, input logic [7:0] l);
      int guard = 0;
      while (!bus.cmd_ready && guard < 1000) begin
         @(posedge clk); #1;
         guard++;
      end
      check({tag, "_cmd_ready_wait"}, 128'(guard < 1000), 128'(1));
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic verify(input string tag, input logic [7:0] a, input logic [7:0] l);
      int n = int'(l) + 1;
      check({tag, "_nreads"}, 128'(q_addr.size()), 128'(n));
      check({tag, "_nwords"}, 128'(q_data.size()), 128'(n));
      for (int i = 0; i < n; i++) begin
         logic [7:0] ea = 8'(int'(a) + i);
         if (i < q_addr.size()) check($sformatf("%s_addr%0d", tag, i), 128'(q_addr[i]), 128'(ea));
         if (i < q_data.size()) begin
            check($sformatf("%s_data%0d", tag, i), q_data[i], word_of(ea));
            check($sformatf("%s_last%0d", tag, i), 128'(q_last[i]), 128'(i == n - 1));
         end
      end
      check({tag, "_invariants"}, 128'(viol), 128'(0));
   endtask

   // mode 0: out_ready=1; mode 1: random ready with three 5-cycle stalls;
   // mode 2: out_ready=1 with stray cmd_valid pulses while busy.
   task automatic run_burst(input string tag, input logic [7:0] a, input logic [7:0] l, input int mode);
      bit done = 1'b0;
      clear_q();
      bus.out_ready = (mode != 1);
      send_cmd(tag, a, l);
      for (int k = 0; k < 2000; k++) begin
         if (q_data.size() >= int'(l) + 1 && bus.cmd_ready) begin
            done = 1'b1;
            break;
         end
         if (mode == 1) begin
            if ((k >= 4 && k < 9) || (k >= 14 && k < 19) || (k >= 24 && k < 29))
               bus.out_ready = 1'b0;
            else
               bus.out_ready = 1'($urandom_range(0, 1));
         end else if (mode == 2) begin
            bus.cmd_valid = (k == 20 || k == 60 || k == 100);
            bus.cmd_addr  = 8'h33;
            bus.cmd_len   = 8'd2;
         end
         @(posedge clk); #1;
      end
      bus.cmd_valid = 1'b0;
      bus.out_ready = 1'b1;
      check({tag, "_done"}, 128'(done), 128'(1));
      repeat (4) @(posedge clk);
      #1;
      verify(tag, a, l);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got4;
      for (int i = 0; i < 256; i++) ram[i] = word_of(8'(i));
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.out_ready = 1'b1;
      bus.bram_dout = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset state
      check("rst_cmd_ready", 128'(bus.cmd_ready), 128'(1));
      check("rst_busy",      128'(bus.busy),      128'(0));
      check("rst_bram_en",   128'(bus.bram_en),   128'(0));
      check("rst_bram_we",   128'(bus.bram_we),   128'(0));
      check("rst_bram_addr", 128'(bus.bram_addr), 128'(0));
      check("rst_out_valid", 128'(bus.out_valid), 128'(0));
      check("rst_out_data",  bus.out_data,        128'(0));
      check("rst_out_last",  128'(bus.out_last),  128'(0));

      // Single word: read at T+1, word at T+3, cmd_ready back at T+4
      run_burst("single", 8'h10, 8'd0, 0);
      if (q_en_cyc.size() > 0)  check("single_en_lat",   128'(q_en_cyc[0] - fire_cyc),  128'(1));
      if (q_pop_cyc.size() > 0) check("single_out_lat",  128'(q_pop_cyc[0] - fire_cyc), 128'(3));
      check("single_ready_lat", 128'(rdy_rise - fire_cyc), 128'(4));

      // Full-rate burst: 8 back-to-back reads and words
      run_burst("full_rate", 8'h00, 8'd7, 0);
      if (q_en_cyc.size() == 8)  check("full_rate_en_span",  128'(q_en_cyc[7] - q_en_cyc[0]),   128'(7));
      if (q_pop_cyc.size() == 8) check("full_rate_out_span", 128'(q_pop_cyc[7] - q_pop_cyc[0]), 128'(7));

      // Address wrap 0xFE -> 0x01
      run_burst("wrap", 8'hFE, 8'd3, 0);

      // Backpressure: credit limit must be reached and respected
      run_burst("bp", 8'h20, 8'd15, 1);
      check("bp_credit_full_seen", 128'(full_seen > 0), 128'(1));

      // Full length with stray commands ignored
      run_burst("full_len", 8'h80, 8'd255, 2);
      check("full_len_one_cmd",  128'(n_fire),        128'(1));
      check("full_len_busy_end", 128'(bus.busy),      128'(0));
      check("full_len_ready",    128'(bus.cmd_ready), 128'(1));

      // Reset mid-burst after 4 words
      clear_q();
      bus.out_ready = 1'b1;
      send_cmd("midrst", 8'h00, 8'd15);
      got4 = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (q_data.size() >= 4) begin
            got4 = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("midrst_4_words", 128'(got4), 128'(1));
      check("midrst_busy_before", 128'(bus.busy), 128'(1));
      rst_n = 1'b0;
      #1;
      check("midrst_bram_en",   128'(bus.bram_en),   128'(0));
      check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
      check("midrst_busy",      128'(bus.busy),      128'(0));
      check("midrst_cmd_ready", 128'(bus.cmd_ready), 128'(1));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_q();
      repeat (5) @(posedge clk);
      #1;
      check("midrst_no_reads", 128'(q_addr.size()), 128'(0));
      check("midrst_no_words", 128'(q_data.size()), 128'(0));
      run_burst("post_rst", 8'h40, 8'd1, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side streamer that sits directly downstream of a 128x256 dual-port block RAM port, driving that port's enable and address and consuming its registered read data.
- Accepts a burst command (start address, length), issues sequential one-word reads, and presents the words as a valid/ready stream with a last flag.
- Absorbs the RAM's 1-cycle read latency and downstream backpressure in a 3-entry skid FIFO, so sustained throughput is 1 word/cycle.

Parameters:
- DATA_W, 128, word width; equals RAM port width.
- ADDR_W, 8, RAM address width (256 words).
- FIFO_DEPTH, 3, skid FIFO entries; fixed, other values unsupported.

Ports:
- clk  in  1  single clock; RAM port is clocked by the same clk.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  block is idle and can accept a command.
- cmd_addr  in  ADDR_W  first word address.
- cmd_len  in  ADDR_W  word count minus 1 (0 -> 1 word, 255 -> 256 words).
- bram_en  out  1  RAM port enable (read).
- bram_we  out  1  RAM write enable; tied 0.
- bram_addr  out  ADDR_W  RAM address.
- bram_dout  in  DATA_W  RAM read data; valid the cycle after bram_en.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  stream word.
- out_last  out  1  final word of the burst.
- busy  out  1  burst in progress (not idle).

Behaviour:
- Reset (async assert, sync release): state IDLE, cmd_ready=1, busy=0, bram_en=0, bram_addr=0, out_valid=0, out_data=0, out_last=0, FIFO empty, counters 0. Asserting reset mid-burst abandons the burst; no partial words are emitted after release.
- States:
  - IDLE: cmd_ready=1. A command handshake in cycle T latches addr and len and moves to ISSUE.
  - ISSUE: issues reads until len+1 reads are done, then moves to DRAIN.
  - DRAIN: waits until the last word is popped, then returns to IDLE; cmd_ready is 1 the cycle after the last pop.
- Read issue:
  - bram_en and bram_addr are registered outputs.
  - A read is issued in a cycle when in ISSUE, reads remain, and fifo_count + rd_pending < 3.
    - fifo_count: registered occupancy at cycle start.
    - rd_pending: bram_en registered from the previous cycle.
  - This rule guarantees no FIFO overflow.
- Address: increments by 1 per issued read, modulo 2^ADDR_W; 255 wraps to 0.
- Capture: when rd_pending=1, bram_dout is pushed into the FIFO with last = (this is read number len+1).
- Latency:
  - cmd handshake at T -> first bram_en at T+1.
  - Data on bram_dout at T+2; first out_valid at T+3.
- Output:
  - out_valid = FIFO non-empty; out_data and out_last come from the FIFO head.
  - Pop when out_valid and out_ready; push and pop in the same cycle are legal, and count is unchanged.
  - out_valid and head data hold stable while out_ready=0.
- Throughput: with out_ready held 1, one read issued and one word emitted every cycle after fill.
- cmd_valid while busy: ignored (cmd_ready=0); the command is not queued.
- out_last is asserted on exactly one word per burst.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults; state enum {IDLE, ISSUE, DRAIN}.
- One sub-module, bram_skid_fifo: 3-entry, DATA_W+1 wide, with push, pop, count, and head outputs.
- The FSM, address/length counters and credit logic stay in the top level.

Test Plan:
- Single word: addr=0x10, len=0, out_ready=1, RAM[0x10]=A -> bram_en exactly 1 cycle at T+1 with addr 0x10; out_valid at T+3 with data A, out_last=1; cmd_ready=1 at T+4.
- Full-rate burst: addr=0x00, len=7, out_ready=1 -> bram_en high 8 consecutive cycles (addr 0..7); 8 consecutive output words RAM[0..7]; out_last only on word 8.
- Wrap: addr=0xFE, len=3 -> reads at 0xFE, 0xFF, 0x00, 0x01 in that order; data matches.
- Backpressure: len=15, out_ready toggles 1/0 randomly with 3 stalls of 5 cycles -> no word lost or duplicated; FIFO count never exceeds 3; bram_en low while fifo_count + rd_pending = 3.
- Full length: len=255 -> exactly 256 words; busy drops after the last pop; cmd_valid pulses mid-burst are ignored.
- Reset mid-burst: assert rst_n=0 after 4 words of len=15 -> bram_en, out_valid and busy drop to 0 immediately. After release, a new burst addr=0x40, len=1 streams RAM[0x40] and RAM[0x41] only.
